// File: rtl/intc_vec.sv
// intc_vec: parametrised vectored interrupt controller.
// Captures rising edges on the done lines into PENDING and masks them with MASK.
// It arbitrates by fixed priority or round-robin and presents irq/addr to the
// core through a four-phase iack handshake. A small register window exposes
// MASK, PENDING, CTRL and STATUS.
module intc_vec #(
    parameter int          NUM_SRC    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int          VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] done,
    input  logic               iack,
    output logic               irq,
    output logic [31:0]        addr,
    input  logic               we,
    input  logic [1:0]         a,
    input  logic [31:0]        wd,
    output logic [31:0]        rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [5:0] NSRC6   = 6'(NUM_SRC);
    localparam logic [4:0] LAST_ID = 5'(NUM_SRC - 1);

    state_t             state_q, state_d;
    logic [4:0]         id_q, id_d;
    logic [31:0]        addr_q, addr_d;
    logic [4:0]         rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0] done_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [1:0]         ctrl_q, ctrl_d;

    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] rot;
    logic [4:0]         fix_id;
    logic [4:0]         rot_off;
    logic [5:0]         rr_sum;
    logic [4:0]         win_id;
    logic               en;
    logic               mode;
    logic               in_service;
    logic               unused_wd;

    assign en         = ctrl_q[0];
    assign mode       = ctrl_q[1];
    assign evt        = done & ~done_q;
    assign req        = pending_q & mask_q;
    assign in_service = (state_q != IDLE);
    assign irq        = (state_q == REQ);
    assign addr       = addr_q;
    // Upper write-data bits are architecturally ignored for narrow builds.
    assign unused_wd  = ^wd;

    // Arbiter: lowest set index, either absolute or counted from rr_ptr.
    always_comb begin
        fix_id  = 5'd0;
        rot_off = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                fix_id = 5'(i);
            end
        end
        // Rotate so that bit 0 is the source at rr_ptr; then wrap back.
        rot = NUM_SRC'({req, req} >> rr_ptr_q);
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_off = 5'(i);
            end
        end
        rr_sum = {1'b0, rr_ptr_q} + {1'b0, rot_off};
        if (rr_sum >= NSRC6) begin
            rr_sum = rr_sum - NSRC6;
        end
        win_id = mode ? rr_sum[4:0] : fix_id;
    end

    // Handshake FSM next-state: grant in IDLE, hold in REQ, wait iack low in ACK.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        rr_ptr_d = rr_ptr_q;
        ack_clr  = '0;
        case (state_q)
            IDLE: begin
                if (en && (|req)) begin
                    id_d    = win_id;
                    addr_d  = VEC_BASE + 32'(VEC_STRIDE) * {27'd0, win_id};
                    state_d = REQ;
                end
            end
            REQ: begin
                // Once raised, the request is only retired by iack.
                if (iack) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (5'(i) == id_q) begin
                            ack_clr[i] = 1'b1;
                        end
                    end
                    if (mode) begin
                        rr_ptr_d = (id_q == LAST_ID) ? 5'd0 : id_q + 5'd1;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!iack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake FSM state, serviced id, vector and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            id_q     <= 5'd0;
            addr_q   <= VEC_BASE;
            rr_ptr_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Register-window next-state; a new event beats any clear in the same cycle.
    always_comb begin
        w1c       = (we && a == 2'd1) ? wd[NUM_SRC-1:0] : '0;
        pending_d = (pending_q & ~(w1c | ack_clr)) | evt;
        mask_d    = (we && a == 2'd0) ? wd[NUM_SRC-1:0] : mask_q;
        ctrl_d    = (we && a == 2'd2) ? wd[1:0] : ctrl_q;
    end

    // Edge-detect history and software-visible registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q    <= '0;
            pending_q <= '0;
            mask_q    <= '1;
            ctrl_q    <= 2'b01;
        end else begin
            done_q    <= done;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            ctrl_q    <= ctrl_d;
        end
    end

    // Combinational read mux; STATUS shows an id only while a source is in service.
    always_comb begin
        case (a)
            2'd0:    rd = 32'(mask_q);
            2'd1:    rd = 32'(pending_q);
            2'd2:    rd = {30'd0, ctrl_q};
            default: rd = {in_service, 26'd0, (in_service ? id_q : 5'd0)};
        endcase
    end

endmodule
